// File: rtl/micro_sequencer_pkg.sv
// Shared constants, state encodings and micro-instruction layout for the micro-sequencer.
package micro_sequencer_pkg;

  localparam int CPU_STATES     = 6;
  localparam int CPU_STATE_W    = $clog2(CPU_STATES);
  localparam int ALU_OPS        = 8;
  localparam int ALU_OP_W       = $clog2(ALU_OPS);
  localparam int DATA_WIDTH     = 16;
  localparam int REG_SPEC_WIDTH = 4;
  localparam int UPC_W          = 10;
  localparam int UWORD_W        = 44;
  localparam int IMM_W          = 11;

  localparam logic REG_FILE_READ  = 1'b0;
  localparam logic REG_FILE_WRITE = 1'b1;

  // Micro-instruction field bit positions
  localparam int OP_HI   = 43, OP_LO   = 41;
  localparam int DST_HI  = 40, DST_LO  = 36;
  localparam int SRC_HI  = 35, SRC_LO  = 31;
  localparam int IMM_HI  = 30, IMM_LO  = 20;
  localparam int TGT_HI  = 19, TGT_LO  = 10;
  localparam int AOP_HI  = 9,  AOP_LO  = 7;
  localparam int RSVD_HI = 6;

  typedef enum logic [CPU_STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXECUTE1 = 3'd3,
    ST_EXECUTE2 = 3'd4,
    ST_HALT     = 3'd5
  } cpu_state_e;

  localparam logic [2:0] OP_NOP       = 3'd0;
  localparam logic [2:0] OP_ALU_REG   = 3'd1;
  localparam logic [2:0] OP_ALU_IMM   = 3'd2;
  localparam logic [2:0] OP_REG_READ  = 3'd3;
  localparam logic [2:0] OP_REG_WRITE = 3'd4;
  localparam logic [2:0] OP_BRANCH_Z  = 3'd5;
  localparam logic [2:0] OP_JUMP      = 3'd6;
  localparam logic [2:0] OP_HALT      = 3'd7;

  typedef struct packed {
    logic [2:0]                op;
    logic [REG_SPEC_WIDTH-1:0] dst;
    logic [REG_SPEC_WIDTH-1:0] src;
    logic [IMM_W-1:0]          imm;
    logic [UPC_W-1:0]          tgt;
    logic [ALU_OP_W-1:0]       aop;
  } uinstr_t;

endpackage

// File: rtl/micro_sequencer_field_dec.sv
// Pure combinational split of a latched micro-instruction word into its fields.
module uinstr_field_dec
  import micro_sequencer_pkg::*;
(
  input  logic [UWORD_W-1:0] i_word,
  output uinstr_t            o_fields
);

  // Reserved bits and upper register-spec bits carry no meaning here
  logic w_unused_bits;
  assign w_unused_bits = ^{i_word[RSVD_HI:0],
                           i_word[DST_HI:DST_LO+REG_SPEC_WIDTH],
                           i_word[SRC_HI:SRC_LO+REG_SPEC_WIDTH]};

  assign o_fields.op  = i_word[OP_HI:OP_LO];
  assign o_fields.dst = i_word[DST_LO+REG_SPEC_WIDTH-1:DST_LO];
  assign o_fields.src = i_word[SRC_LO+REG_SPEC_WIDTH-1:SRC_LO];
  assign o_fields.imm = i_word[IMM_HI:IMM_LO];
  assign o_fields.tgt = i_word[TGT_HI:TGT_LO];
  assign o_fields.aop = i_word[AOP_HI:AOP_LO];

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: fetch / decode / two-cycle execute loop over a 1K micro-store.
module micro_sequencer
  import micro_sequencer_pkg::*;
(
  input  logic                      sys_clk,
  input  logic                      sys_reset,
  input  logic                      start,
  output logic                      imem_req,
  output logic [UPC_W-1:0]          imem_addr,
  input  logic                      imem_ack,
  input  logic [UWORD_W-1:0]        imem_rdata,
  input  logic                      alu_zero,
  output logic [CPU_STATE_W-1:0]    cpu_state,
  output logic                      reg_file_en,
  output logic                      reg_file_rw,
  output logic [REG_SPEC_WIDTH-1:0] reg_sel,
  output logic [DATA_WIDTH-1:0]     reg_wr_data,
  output logic                      alu_en,
  output logic [ALU_OP_W-1:0]       alu_op,
  output logic                      halted
);

  cpu_state_e         r_state, w_next;
  logic [UPC_W-1:0]   r_upc;
  logic [UWORD_W-1:0] r_word;
  uinstr_t            w_f;
  logic               w_exec, w_take;

  uinstr_field_dec u_dec (
    .i_word   (r_word),
    .o_fields (w_f)
  );

  assign w_exec = (r_state == ST_EXECUTE1) || (r_state == ST_EXECUTE2);
  // alu_zero only matters on the EXECUTE2 edge, where w_take is consumed
  assign w_take = (w_f.op == OP_JUMP) || ((w_f.op == OP_BRANCH_Z) && alu_zero);

  // State register
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  // Next-state logic; start only honoured from IDLE and HALT
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_FETCH;
      ST_FETCH:    if (imem_ack) w_next = ST_DECODE;
      ST_DECODE:   w_next = (w_f.op == OP_HALT) ? ST_HALT : ST_EXECUTE1;
      ST_EXECUTE1: w_next = ST_EXECUTE2;
      ST_EXECUTE2: w_next = ST_FETCH;
      ST_HALT:     if (start) w_next = ST_FETCH;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Micro-PC and instruction latch
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      r_upc  <= '0;
      r_word <= '0;
    end else begin
      if (((r_state == ST_IDLE) || (r_state == ST_HALT)) && start) r_upc <= '0;
      if ((r_state == ST_FETCH) && imem_ack)                       r_word <= imem_rdata;
      // Natural 10-bit overflow gives the 1023 -> 0 wrap
      if (r_state == ST_EXECUTE2) r_upc <= w_take ? w_f.tgt : r_upc + 1'b1;
    end
  end

  // Outputs decoded from state and latched word; all zero outside their phase
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    reg_file_en = 1'b0;
    reg_file_rw = REG_FILE_READ;
    reg_sel     = '0;
    reg_wr_data = '0;
    alu_en      = 1'b0;
    alu_op      = '0;
    halted      = (r_state == ST_HALT);
    if (r_state == ST_FETCH) begin
      imem_req  = 1'b1;
      imem_addr = r_upc;
    end
    if (w_exec) begin
      if ((w_f.op == OP_REG_READ) || (w_f.op == OP_REG_WRITE)) begin
        reg_file_en = 1'b1;
        reg_file_rw = (w_f.op == OP_REG_WRITE) ? REG_FILE_WRITE : REG_FILE_READ;
        reg_sel     = (w_f.op == OP_REG_WRITE) ? w_f.dst : w_f.src;
        reg_wr_data = {{(DATA_WIDTH-IMM_W){1'b0}}, w_f.imm};
      end
      if ((w_f.op == OP_ALU_REG) || (w_f.op == OP_ALU_IMM)) begin
        alu_en = 1'b1;
        alu_op = w_f.aop;
      end
    end
  end

  assign cpu_state = r_state;

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: sys_clk  in  1  rising-edge clock; sys_reset  in  1  asynchronous active-low reset.
REQ-002 SHALL have port start  in  1: begin execution from micro-PC 0 (from IDLE or HALT).
REQ-003 SHALL have port imem_req  out  1: micro-instruction fetch request.
REQ-004 SHALL have port imem_addr  out  10: micro-PC being fetched.
REQ-005 SHALL have port imem_ack  in  1: fetch data valid this cycle.
REQ-006 SHALL have port imem_rdata  in  44: micro-instruction word.
REQ-007 SHALL have port alu_zero  in  1: ALU zero flag, used as branch condition.
REQ-008 SHALL have port cpu_state  out  clog2(CPU_STATES): current sequencer state.
REQ-009 SHALL have ports reg_file_en, reg_file_rw  out  1 each: register-file enable and direction (REG_FILE_READ/REG_FILE_WRITE).
REQ-010 SHALL have port reg_sel  out  REG_SPEC_WIDTH: register select.
REQ-011 SHALL have port reg_wr_data  out  DATA_WIDTH: imm zero-extended.
REQ-012 SHALL have ports alu_en  out  1 and alu_op  out  clog2(ALU_OPS).
REQ-013 SHALL have port halted  out  1: high while in HALT.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, EXECUTE1, EXECUTE2, HALT, with encodings from the shared defines.
REQ-015 SHALL go IDLE->FETCH and set upc=0 on start; start is ignored in all other states except HALT.
REQ-016 FETCH SHALL assert imem_req with imem_addr=upc, holding both stable until imem_ack; on ack it SHALL latch imem_rdata and go to DECODE; a stall of any length is legal.
REQ-017 SHALL ignore imem_ack outside FETCH.
REQ-018 Word fields: [43:41] op; [40:36] dst (low REG_SPEC_WIDTH bits used); [35:31] src; [30:20] imm; [19:10] branch_target; [9:7] alu_op; [6:0] reserved, ignored.
REQ-019 Opcodes: 0 NOP, 1 ALU_REG, 2 ALU_IMM, 3 REG_READ (sel=src), 4 REG_WRITE (sel=dst), 5 BRANCH_Z, 6 JUMP, 7 HALT.
REQ-020 DECODE SHALL take exactly 1 cycle, then go to EXECUTE1, or to HALT when op=7.
REQ-021 In EXECUTE1 and EXECUTE2, SHALL hold reg_file_en=1 for ops 3/4, with reg_file_rw, reg_sel and reg_wr_data stable across both cycles; alu_en=1 with alu_op for ops 1/2.
REQ-022 Outside EXECUTE1/EXECUTE2, SHALL drive reg_file_en=0 and alu_en=0.
REQ-023 At the EXECUTE2 exit, SHALL update next upc: JUMP -> branch_target; BRANCH_Z with alu_zero=1 sampled in EXECUTE2 -> branch_target; otherwise upc+1, wrapping 1023->0. It SHALL then go to FETCH.
REQ-024 HALT SHALL assert halted=1; start SHALL set upc=0 and go to FETCH.
REQ-025 Per-micro-instruction latency SHALL be 4 cycles plus imem stall cycles.

Reset
REQ-026 While sys_reset=0, SHALL force cpu_state=IDLE, upc=0, latched word=0, and all outputs 0 (imem_req=0 immediately, asynchronously).
REQ-027 On reset release, SHALL stay in IDLE until start.
REQ-028 Reset mid-fetch or mid-execute SHALL abort the operation with no register-file enable pulse.

Structure
REQ-029 The shared defines/package SHALL hold CPU_STATES and the state encodings (incl. EXECUTE1/EXECUTE2), opcode constants, ALU_OPS, DATA_WIDTH, REG_SPEC_WIDTH, REG_FILE_READ/WRITE, and the field bit positions.
REQ-030 The field extraction SHALL be one combinational sub-module, uinstr_field_dec; the FSM and upc SHALL live in micro_sequencer.

Verification
REQ-031 Reset, start, word op=4 dst=3 imm=0x05A, ack after 0 stall -> EXECUTE1/2: reg_file_en=1, rw=WRITE, reg_sel=3, reg_wr_data=0x05A; upc becomes 1.
REQ-032 imem_ack delayed 5 cycles -> imem_req/imem_addr stable throughout; DECODE follows the ack cycle.
REQ-033 BRANCH_Z target=0x200: alu_zero=1 -> next imem_addr=0x200; alu_zero=0 -> upc+1.
REQ-034 upc=1023, op=NOP -> next imem_addr=0; op=JUMP target=5 at 1023 -> 5.
REQ-035 op=7 -> halted=1 with no reg/alu enables; start -> imem_addr=0, FETCH.
REQ-036 sys_reset asserted in EXECUTE1 -> all outputs 0 immediately, IDLE; start ignored in EXECUTE2.
